// File: rtl/hamming_correct.sv
// SECDED decode/correct stage: two registered stages with valid/ready, single-error
// correction, payload extraction and saturating error counters. Optional log: HAMMING_ERR_LOG_EN.
module hamming_correct #(
  parameter  int DATA_WIDTH  = 32,
  parameter  int COUNT_WIDTH = 16,
  localparam int ADDR_WIDTH  = $clog2(DATA_WIDTH + $clog2(DATA_WIDTH) + 1),
  localparam int CODED_WIDTH = 1 << ADDR_WIDTH
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
`ifdef HAMMING_ERR_LOG_EN
  output logic                   err_log_valid_o,
  output logic [ADDR_WIDTH-1:0]  err_log_syndrome_o,
  output logic                   err_log_double_o,
`endif
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [CODED_WIDTH-1:0] coded_i,
  input  logic [ADDR_WIDTH-1:0]  syndrome_i,
  input  logic                   ext_parity_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [DATA_WIDTH-1:0]  data_o,
  output logic                   err_single_o,
  output logic                   err_double_o,
  input  logic                   clear_counts_i,
  output logic [COUNT_WIDTH-1:0] corr_count_o,
  output logic [COUNT_WIDTH-1:0] uncorr_count_o
);

  // Coded position carrying payload bit k: k-th non-power-of-two position >= 3.
  function automatic int data_pos(input int k);
    int cnt;
    int pos;
    cnt = 0;
    pos = 0;
    for (int p = 3; p < CODED_WIDTH; p++) begin
      if ((p & (p - 1)) != 0) begin
        if (cnt == k) pos = p;
        cnt++;
      end
    end
    return pos;
  endfunction

  function automatic logic [CODED_WIDTH-1:0] used_mask();
    logic [CODED_WIDTH-1:0] m;
    m = '0;
    for (int k = 0; k < DATA_WIDTH; k++) m[data_pos(k)] = 1'b1;
    return m;
  endfunction

  localparam int                     LAST_POS  = data_pos(DATA_WIDTH - 1);
  localparam logic [ADDR_WIDTH-1:0]  LAST_SYN  = LAST_POS[ADDR_WIDTH-1:0];
  localparam logic [CODED_WIDTH-1:0] USED_MSK  = used_mask();
  localparam logic [CODED_WIDTH-1:0] ONE_HOT_0 = {{(CODED_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [COUNT_WIDTH-1:0] CNT_MAX   = {COUNT_WIDTH{1'b1}};

  // Handshake: a word moves on valid & ready in the same cycle; each stage advances
  // when its downstream slot is empty or being drained, so throughput is one per clock.
  logic                   s1_valid;
  logic [CODED_WIDTH-1:0] s1_coded;
  logic [ADDR_WIDTH-1:0]  s1_syn;
  logic                   s1_ovr;
  logic                   s2_en;
  logic                   s2_load;

  assign s2_en      = !out_valid_o || out_ready_i;
  assign in_ready_o = !s1_valid || s2_en;
  assign s2_load    = s1_valid && s2_en;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      s1_valid <= 1'b0;
      s1_coded <= '0;
      s1_syn   <= '0;
      s1_ovr   <= 1'b0;
    end else if (in_ready_o) begin
      s1_valid <= in_valid_i;
      if (in_valid_i) begin
        s1_coded <= coded_i;
        s1_syn   <= syndrome_i;
        s1_ovr   <= ext_parity_i ^ coded_i[0];
      end
    end
  end

  logic                   syn_zero;
  logic                   syn_in_range;
  logic                   is_single;
  logic                   is_double;
  logic [CODED_WIDTH-1:0] corrected;
  logic [DATA_WIDTH-1:0]  extracted;
  logic                   unused_bits;

  assign syn_zero     = (s1_syn == '0);
  assign syn_in_range = (s1_syn <= LAST_SYN);
  assign is_single    = s1_ovr && syn_in_range;
  assign is_double    = (!s1_ovr && !syn_zero) || (s1_ovr && !syn_in_range);
  // A zero syndrome with odd overall parity means bit0 itself flipped: no payload change.
  assign corrected    = (is_single && !syn_zero) ? (s1_coded ^ (ONE_HOT_0 << s1_syn)) : s1_coded;
  assign unused_bits  = ^(corrected & ~USED_MSK);

  for (genvar k = 0; k < DATA_WIDTH; k++) begin : g_extract
    localparam int POS = data_pos(k);
    assign extracted[k] = corrected[POS];
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      out_valid_o  <= 1'b0;
      data_o       <= '0;
      err_single_o <= 1'b0;
      err_double_o <= 1'b0;
    end else if (s2_en) begin
      out_valid_o <= s1_valid;
      if (s1_valid) begin
        data_o       <= extracted;
        err_single_o <= is_single;
        err_double_o <= is_double;
      end
    end
  end

  // Clear has priority over a same-cycle increment.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      corr_count_o   <= '0;
      uncorr_count_o <= '0;
    end else if (clear_counts_i) begin
      corr_count_o   <= '0;
      uncorr_count_o <= '0;
    end else begin
      if (s2_load && is_single && (corr_count_o != CNT_MAX))
        corr_count_o <= corr_count_o + 1'b1;
      if (s2_load && is_double && (uncorr_count_o != CNT_MAX))
        uncorr_count_o <= uncorr_count_o + 1'b1;
    end
  end

`ifdef HAMMING_ERR_LOG_EN
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      err_log_valid_o    <= 1'b0;
      err_log_syndrome_o <= '0;
      err_log_double_o   <= 1'b0;
    end else if (clear_counts_i) begin
      err_log_valid_o    <= 1'b0;
      err_log_syndrome_o <= '0;
      err_log_double_o   <= 1'b0;
    end else if (!err_log_valid_o && s2_load && (is_single || is_double)) begin
      err_log_valid_o    <= 1'b1;
      err_log_syndrome_o <= s1_syn;
      err_log_double_o   <= is_double;
    end
  end
`endif

endmodule
